// File: rtl/vga_line_loader.sv
// +----------------------------------------------------------------------------+
// | vga_line_loader: fetches one 256-pixel row from framebuffer memory and      |
// | writes it as 64 words into the VGA line buffer.                             |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module vga_line_loader #(
   parameter int                    ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] FB_BASE    = '0,
   parameter int                    ROWS       = 192
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [7:0]            row,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ack,
   input  logic [31:0]           mem_data,
   output logic                  wr_en,
   output logic [5:0]            wr_addr,
   output logic [31:0]           wr_data
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REQ   = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;

   logic [1:0]            r_state;
   logic [5:0]            r_idx;
   logic                  r_blank;
   logic [ADDR_WIDTH-1:0] r_rbase;

   logic                  w_blank;
   logic [ADDR_WIDTH-1:0] w_row_base;
   logic [5:0]            w_idx_next;
   logic [ADDR_WIDTH-1:0] w_next_addr;

   // Address arithmetic wraps modulo 2^ADDR_WIDTH by construction.
   assign w_blank     = (int'(row) >= ROWS);
   assign w_row_base  = FB_BASE + ADDR_WIDTH'({row, 8'h00});
   assign w_idx_next  = r_idx + 6'd1;
   assign w_next_addr = r_rbase + ADDR_WIDTH'({w_idx_next, 2'b00});

   // All outputs are flops updated on state transitions, so nothing is
   // combinationally reachable from an input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_blank  <= 1'b0;
         r_rbase  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         mem_req  <= 1'b0;
         mem_addr <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
      end else begin
         done  <= 1'b0;
         wr_en <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_idx   <= '0;
                  r_blank <= w_blank;
                  r_rbase <= w_row_base;
                  busy    <= 1'b1;
                  if (w_blank) begin
                     r_state <= S_WRITE;
                     wr_en   <= 1'b1;
                     wr_addr <= '0;
                     wr_data <= '0;
                  end else begin
                     r_state  <= S_REQ;
                     mem_req  <= 1'b1;
                     mem_addr <= w_row_base;
                  end
               end
            end
            S_REQ: begin
               if (mem_ack) begin
                  r_state <= S_WRITE;
                  mem_req <= 1'b0;
                  wr_en   <= 1'b1;
                  wr_addr <= r_idx;
                  wr_data <= mem_data;
               end
            end
            S_WRITE: begin
               if (r_idx == 6'd63) begin
                  r_state <= S_IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  r_idx <= w_idx_next;
                  if (r_blank) begin
                     wr_en   <= 1'b1;
                     wr_addr <= w_idx_next;
                     wr_data <= '0;
                  end else begin
                     r_state  <= S_REQ;
                     mem_req  <= 1'b1;
                     mem_addr <= w_next_addr;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_vga_line_loader.sv
// +----------------------------------------------------------------------------+
// | tb_vga_line_loader: scoreboard bench with a memory responder and a         |
// | row-level reference model of the expected line-buffer writes.              |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_vga_line_loader;

   localparam int          ADDR_WIDTH = 16;
   localparam logic [15:0] FB_BASE    = 16'h0000;
   localparam int          ROWS       = 192;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  row = 8'd0;
   logic        busy, done, mem_req, wr_en;
   logic [15:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_data = 32'd0;
   logic [5:0]  wr_addr;
   logic [31:0] wr_data;

   vga_line_loader #(.ADDR_WIDTH(ADDR_WIDTH), .FB_BASE(FB_BASE), .ROWS(ROWS)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .row(row), .busy(busy), .done(done),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          addr;
      logic [31:0] data;
      bit          blank;
      int          exp_cyc;
   } wr_t;

   wr_t wr_q[$];
   int  addr_q[$];
   int  n_checks = 0;
   int  n_pass = 0;
   int  ack_mode = 0;       // fixed ack delay, or -1 for random 0..3
   int  data_mode = 0;      // 0: word equals its byte address
   bit  spur_en = 1'b0;
   int  ack_cyc = -100;
   int  exp_done_cyc = -1;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic note_fail(input string name, input longint act);
      n_checks++;
      $display("FAIL %s: got %0h, expected nothing (t=%0t)", name, act, $time);
   endtask

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      if (data_mode == 0) return {16'h0000, a};
      return {a ^ 16'hA5C3, ~a};
   endfunction

   // Reference model: one start yields 64 writes of row pixels in column order.
   task automatic issue_start(input logic [7:0] r);
      int a;
      wr_t e;
      start = 1'b1;
      row   = r;
      for (int k = 0; k < 64; k++) begin
         a = (int'(FB_BASE) + int'(r) * 256 + 4 * k) % 65536;
         e.addr = k;
         if (int'(r) >= ROWS) begin
            e.data = 32'h0; e.blank = 1'b1; e.exp_cyc = cyc + 1 + k;
         end else begin
            addr_q.push_back(a);
            e.data = mem_word(a[15:0]); e.blank = 1'b0; e.exp_cyc = 0;
         end
         wr_q.push_back(e);
      end
   endtask

   task automatic wait_done(input int budget, input int mid_at, output int dcyc);
      bit seen = 1'b0;
      bit busy_ok = 1'b1;
      dcyc = -1;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (i == mid_at) begin start = 1'b1; row = 8'd7; end
         if (done) begin
            seen = 1'b1; dcyc = cyc;
            if (busy) busy_ok = 1'b0;
         end else if (!busy) busy_ok = 1'b0;
      end
      check("done_seen", longint'(seen), 1);
      check("busy_window", longint'(busy_ok), 1);
   endtask

   // Memory responder: acks after a (possibly random) delay, checks addresses.
   int          rsp_cnt = 0;
   int          rsp_dly = 0;
   bit          in_req = 1'b0;
   logic [15:0] req_addr = 16'h0;
   always @(negedge clk) begin
      mem_ack = 1'b0;
      if (!rst_n) in_req = 1'b0;
      else if (mem_req) begin
         if (!in_req) begin
            in_req = 1'b1; req_addr = mem_addr; rsp_cnt = 0;
            rsp_dly = (ack_mode < 0) ? int'($urandom_range(0, 3)) : ack_mode;
            if (addr_q.size() == 0) note_fail("unexpected_req", longint'(mem_addr));
            else check("mem_addr", longint'(mem_addr), longint'(addr_q.pop_front()));
         end else check("addr_stable", longint'(mem_addr), longint'(req_addr));
         if (rsp_cnt == rsp_dly) begin
            mem_ack = 1'b1; mem_data = mem_word(mem_addr); ack_cyc = cyc; in_req = 1'b0;
         end else rsp_cnt++;
      end else if (spur_en && $urandom_range(0, 2) == 0) begin
         mem_ack = 1'b1; mem_data = $urandom;
      end
   end

   // Monitor: pops the scoreboard on every line-buffer write and on done.
   wr_t mon_e;
   always @(negedge clk) begin
      if (rst_n) begin
         if (wr_en) begin
            if (wr_q.size() == 0) note_fail("unexpected_write", longint'(wr_addr));
            else begin
               mon_e = wr_q.pop_front();
               check("wr_addr", longint'(wr_addr), longint'(mon_e.addr));
               check("wr_data", longint'(wr_data), longint'(mon_e.data));
               if (mon_e.blank) check("wr_cycle_blank", longint'(cyc), longint'(mon_e.exp_cyc));
               else check("wr_after_ack", longint'(cyc), longint'(ack_cyc + 1));
               if (mon_e.addr == 63) exp_done_cyc = cyc + 1;
            end
         end
         if (done || (exp_done_cyc >= 0 && cyc == exp_done_cyc)) begin
            check("done_cycle", done ? longint'(cyc) : -1, longint'(exp_done_cyc));
            exp_done_cyc = -1;
         end
      end
   end

   initial begin
      int  s, d;
      bit  saw, found;
      logic [7:0] r;

      repeat (3) @(negedge clk);
      check("reset_outputs", longint'({busy, done, mem_req, wr_en, mem_addr, wr_addr, wr_data}), 0);
      rst_n = 1'b1;
      saw = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (mem_req || wr_en || busy || done) saw = 1'b1;
      end
      check("idle_quiet", longint'(saw), 0);

      // Row 0, zero-wait ack, word equals address.
      ack_mode = 0; data_mode = 0;
      s = cyc; issue_start(8'd0); wait_done(400, -1, d);
      check("done_latency_row0", longint'(d - s), 129);

      // Last valid row with 3-cycle ack delay.
      ack_mode = 3;
      issue_start(8'd191); wait_done(600, -1, d);

      // Blank row with spurious acks during WRITE and while idle.
      ack_mode = 0; spur_en = 1'b1;
      s = cyc; issue_start(8'd200); wait_done(200, -1, d);
      check("done_latency_blank", longint'(d - s), 65);
      repeat (5) @(negedge clk);

      // Ignored mid-row start, then a start in the done cycle.
      data_mode = 1; ack_mode = -1;
      issue_start(8'd3); wait_done(600, 20, d);
      issue_start(8'd4); wait_done(600, -1, d);

      // Random rows with random ack latency.
      repeat (6) begin
         r = 8'($urandom_range(0, 255));
         issue_start(r); wait_done(800, -1, d);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      // Reset asserted while requesting word 10 of row 5.
      spur_en = 1'b0; ack_mode = 2;
      issue_start(8'd5);
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (mem_req && mem_addr == 16'h0528) found = 1'b1;
      end
      check("reached_row5_word10", longint'(found), 1);
      #2 rst_n = 1'b0;
      #1 check("reset_async", longint'({mem_req, busy, wr_en}), 0);
      wr_q.delete(); addr_q.delete(); exp_done_cyc = -1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      saw = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (mem_req || wr_en || busy || done) saw = 1'b1;
      end
      check("quiet_after_reset", longint'(saw), 0);

      check("scoreboard_drained", longint'(wr_q.size() + addr_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_checks);
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/vga_line_loader.md
Name: vga_line_loader

Overview:
- Fetches one 256-pixel display row (8-bit colour, 256 bytes) from framebuffer memory over a 32-bit request/acknowledge read port.
- Writes the row as 64 consecutive 32-bit words into the VGA line buffer RAM through that RAM's write port (wr_en / wr_addr[5:0] / wr_data[31:0]).
- Sits directly upstream of the line buffer. The VGA timing controller pulses start once per row, ahead of scanout.

Parameters:
- ADDR_WIDTH, 16, width of mem_addr (byte address).
- FB_BASE, 16'h0000, byte address of pixel (row 0, column 0) in framebuffer memory.
- ROWS, 192, number of valid framebuffer rows; row values >= ROWS are blank rows.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse to begin loading a row; ignored while busy=1.
- row  input  8  row index, sampled on the cycle start is accepted.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the last word is written.
- mem_req  output  1  read request; held high until mem_ack.
- mem_addr  output  ADDR_WIDTH  word-aligned byte address; stable while mem_req=1.
- mem_ack  input  1  one-cycle pulse; mem_data valid in the same cycle.
- mem_data  input  32  read data. Bits [7:0] are the byte at mem_addr, bits [31:24] are the byte at mem_addr+3.
- wr_en  output  1  line buffer write enable.
- wr_addr  output  6  line buffer word address.
- wr_data  output  32  line buffer write data.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, mem_req=0, mem_addr=0, wr_en=0, wr_addr=0, wr_data=0; word index=0, blank flag=0. Reset mid-row abandons the row immediately. No further mem_req or wr_en until the next start.
- Internal registers:
  - idx[5:0]: word index.
  - blank: set when row >= ROWS at accept.
  - rbase[ADDR_WIDTH-1:0]: FB_BASE + {row, 8'h00}, truncated to ADDR_WIDTH, computed at accept.
- State IDLE:
  - busy=0.
  - On start=1: capture row, set idx=0, set blank, go to REQ if blank=0, else WRITE with wr_data=0.
  - start while not IDLE: ignored entirely, no queueing.
- State REQ:
  - mem_req=1, mem_addr = rbase + {idx, 2'b00}.
  - On mem_ack=1: register mem_data, go to WRITE. mem_req drops in the cycle after the ack.
  - No timeout; waits indefinitely.
  - mem_ack outside REQ is ignored.
- State WRITE (exactly one cycle):
  - wr_en=1, wr_addr=idx, wr_data = captured word (or 32'h0 if blank). Data passes through without byte swap, so line buffer byte address {idx, k} holds pixel column 4*idx+k.
  - If idx==63: go to IDLE, pulse done=1 in the next cycle, busy=0 in that same cycle.
  - Else: idx <= idx+1, go to REQ (or stay in WRITE with the next idx if blank).
- Timing:
  - Per non-blank word: minimum 1 REQ cycle plus 1 WRITE cycle. With zero-wait ack (mem_ack in the first REQ cycle), a row takes 128 cycles from accept to last write; done follows one cycle later.
  - Blank row: 64 consecutive WRITE cycles, no mem_req. done follows on cycle 65 after accept.
- Outputs:
  - wr_en, mem_req and done are registered (state-decoded from flops); there are no combinational paths from inputs to outputs.
  - wr_addr/wr_data hold their last values when wr_en=0.
- Overflow: address addition wraps modulo 2^ADDR_WIDTH. This is not an error.
- A new start is accepted in the cycle done is high, since the state is already IDLE.

Test Plan:
- Reset then idle for 10 cycles -> all outputs 0, no mem_req, no wr_en. Assert rst_n=0 during REQ of row 5, word 10 -> mem_req and busy fall asynchronously; no writes after release.
- start, row=0, FB_BASE=0, memory returns word = byte address, zero-wait ack -> 64 writes with wr_addr 0..63 and wr_data 0x0000_0000, 0x0000_0004, ..., 0x0000_00FC. done pulses on cycle 129 after accept; busy high on cycles 1..128.
- start, row=191, ack delayed 3 cycles per request -> first mem_addr 0xBF00, last 0xBFFC. mem_addr stable while mem_req=1. Each write occurs exactly 1 cycle after its ack.
- start, row=200 (>= ROWS) -> mem_req never asserted. 64 writes of 32'h0 on consecutive cycles, wr_addr 0..63, then done.
- start pulsed again mid-row (row=7 while loading row=3) -> ignored; all 64 addresses belong to row 3. A start with row=4 in the done cycle -> accepted; first mem_addr 0x0400.
- Spurious mem_ack while IDLE or WRITE -> no state change, no extra write, idx unchanged.
